// File: rtl/money_spawner_if.sv
// rtl/money_spawner_if.sv - player/draw signal bundle between game logic and money_spawner
interface money_spawner_if #(
    parameter int NUM_SLOTS = 4
);
    logic                 SpawnEnable;
    logic [2:0]           Random;
    logic                 P1Collected;
    logic                 P2Collected;
    logic [4:0]           P1HbOffset;
    logic [4:0]           P2HbOffset;
    logic [9:0]           P1X;
    logic [9:0]           P1Y;
    logic [9:0]           P2X;
    logic [9:0]           P2Y;
    logic [9:0]           DrawX;
    logic [9:0]           DrawY;
    logic [1:0]           P1Collect;
    logic [1:0]           P2Collect;
    logic [NUM_SLOTS-1:0] ActiveMask;
    logic                 MoneyPixel;
    logic [1:0]           Tile;
    logic [4:0]           PixelX;
    logic [4:0]           PixelY;

    modport master (
        output SpawnEnable, Random, P1Collected, P2Collected, P1HbOffset, P2HbOffset,
               P1X, P1Y, P2X, P2Y, DrawX, DrawY,
        input  P1Collect, P2Collect, ActiveMask, MoneyPixel, Tile, PixelX, PixelY
    );

    modport slave (
        input  SpawnEnable, Random, P1Collected, P2Collected, P1HbOffset, P2HbOffset,
               P1X, P1Y, P2X, P2Y, DrawX, DrawY,
        output P1Collect, P2Collect, ActiveMask, MoneyPixel, Tile, PixelX, PixelY
    );
endinterface

// File: rtl/money_spawner.sv
// rtl/money_spawner.sv - NUM_SLOTS money pickups with claims, respawn timers and draw outputs; MONEY_DESPAWN_EN adds lifetime despawn
module money_spawner #(
    parameter int         NUM_SLOTS    = 4,
    parameter logic [9:0] SLOT_X0      = 10'd64,
    parameter logic [9:0] SLOT_PITCH   = 10'd128,
    parameter logic [9:0] SPAWN_Y      = 10'd436,
    parameter logic [9:0] MONEY_W      = 10'd18,
    parameter logic [9:0] MONEY_H      = 10'd18,
    parameter logic [9:0] BASE_RESPAWN = 10'd595,
    parameter logic [9:0] DELAY_STEP   = 10'd60,
    parameter logic [9:0] LIFETIME     = 10'd900
) (
    input  logic           FrameClk,
    input  logic           Reset,
    money_spawner_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ACTIVE, COOLDOWN} slot_state_e;

    if (NUM_SLOTS < 1 || NUM_SLOTS > 8 ||
        int'(BASE_RESPAWN) + 7 * int'(DELAY_STEP) > 1023 || int'(LIFETIME) > 1023) begin : g_bad_params
        $error("money_spawner: parameter out of range");
    end

    slot_state_e          state_q [NUM_SLOTS];
    slot_state_e          state_n [NUM_SLOTS];
    logic [1:0]           value_q [NUM_SLOTS];
    logic [1:0]           value_n [NUM_SLOTS];
    logic [2:0]           delay_q [NUM_SLOTS];
    logic [2:0]           delay_n [NUM_SLOTS];
    logic [9:0]           timer_q [NUM_SLOTS];
    logic [9:0]           timer_n [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] active;
    logic [NUM_SLOTS-1:0] p1_hit;
    logic [NUM_SLOTS-1:0] p2_hit;
    logic [NUM_SLOTS-1:0] p1_claim;
    logic [NUM_SLOTS-1:0] p2_claim;
    logic [NUM_SLOTS-1:0] ack;
    logic                 p1_valid;
    logic                 p2_valid;
    logic [1:0]           p1_val;
    logic [1:0]           p2_val;
    logic [10:0]          p1_hx;
    logic [10:0]          p1_hy;
    logic [10:0]          p2_hx;
    logic [10:0]          p2_hy;
    logic                 draw_hit;
    logic [1:0]           draw_tile;
    logic [4:0]           draw_px;
    logic [4:0]           draw_py;

    // Geometry is done at 11 bits so sums near the right/bottom edge never wrap.
    function automatic logic [10:0] slot_x(input int i);
        return 11'(SLOT_X0) + 11'(i) * 11'(SLOT_PITCH);
    endfunction

    function automatic logic overlap(input logic [10:0] hx, input logic [10:0] hy,
                                     input logic [10:0] sx);
        return (hx < sx + 11'(MONEY_W)) && (sx < hx + 11'd16) &&
               (hy < 11'(SPAWN_Y) + 11'(MONEY_H)) && (11'(SPAWN_Y) < hy + 11'd16);
    endfunction

    assign p1_hx = 11'(bus.P1X) + 11'(bus.P1HbOffset);
    assign p1_hy = 11'(bus.P1Y) + 11'd16;
    assign p2_hx = 11'(bus.P2X) + 11'(bus.P2HbOffset);
    assign p2_hy = 11'(bus.P2Y) + 11'd16;

    // P2 skips whatever P1 claimed so both can collect different slots in one frame.
    always_comb begin
        active   = '0;
        p1_hit   = '0;
        p2_hit   = '0;
        p1_claim = '0;
        p2_claim = '0;
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        p1_val   = 2'd0;
        p2_val   = 2'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            active[i] = (state_q[i] == ACTIVE);
            p1_hit[i] = active[i] && overlap(p1_hx, p1_hy, slot_x(i));
            p2_hit[i] = active[i] && overlap(p2_hx, p2_hy, slot_x(i));
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!p1_valid && p1_hit[i]) begin
                p1_valid    = 1'b1;
                p1_claim[i] = 1'b1;
                p1_val      = value_q[i];
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!p2_valid && p2_hit[i] && !p1_claim[i]) begin
                p2_valid    = 1'b1;
                p2_claim[i] = 1'b1;
                p2_val      = value_q[i];
            end
        end
    end

    assign ack = (p1_claim & {NUM_SLOTS{bus.P1Collected}}) |
                 (p2_claim & {NUM_SLOTS{bus.P2Collected}});

    always_comb begin
        draw_hit  = 1'b0;
        draw_tile = 2'd0;
        draw_px   = 5'd0;
        draw_py   = 5'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!draw_hit && active[i] &&
                11'(bus.DrawX) >= slot_x(i) && 11'(bus.DrawX) < slot_x(i) + 11'(MONEY_W) &&
                bus.DrawY >= SPAWN_Y && 11'(bus.DrawY) < 11'(SPAWN_Y) + 11'(MONEY_H)) begin
                draw_hit  = 1'b1;
                draw_tile = value_q[i];
                draw_px   = 5'(bus.DrawX - 10'(slot_x(i)));
                draw_py   = 5'(bus.DrawY - SPAWN_Y);
            end
        end
    end

    assign bus.P1Collect  = p1_val;
    assign bus.P2Collect  = p2_val;
    assign bus.ActiveMask = active;
    assign bus.MoneyPixel = draw_hit & bus.SpawnEnable;
    assign bus.Tile       = draw_tile;
    assign bus.PixelX     = draw_px;
    assign bus.PixelY     = draw_py;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            state_n[i] = state_q[i];
            value_n[i] = value_q[i];
            delay_n[i] = delay_q[i];
            timer_n[i] = timer_q[i];
            if (!bus.SpawnEnable) begin
                state_n[i] = EMPTY;
                value_n[i] = 2'd0;
                delay_n[i] = 3'd0;
                timer_n[i] = 10'd0;
            end else begin
                case (state_q[i])
                    EMPTY: begin
                        state_n[i] = ACTIVE;
                        value_n[i] = 2'(bus.Random[0]) + 2'd1;
                        delay_n[i] = bus.Random ^ 3'(i);
                        timer_n[i] = 10'd0;
                    end
                    ACTIVE: begin
                        if (ack[i]) begin
                            state_n[i] = COOLDOWN;
                            value_n[i] = 2'd0;
                            timer_n[i] = 10'd0;
                        end
`ifdef MONEY_DESPAWN_EN
                        else if (timer_q[i] == LIFETIME) begin
                            state_n[i] = COOLDOWN;
                            value_n[i] = 2'd0;
                            timer_n[i] = 10'd0;
                        end else begin
                            timer_n[i] = timer_q[i] + 10'd1;
                        end
`endif
                    end
                    COOLDOWN: begin
                        if (timer_q[i] == BASE_RESPAWN + 10'(delay_q[i]) * DELAY_STEP) begin
                            state_n[i] = EMPTY;
                        end else begin
                            timer_n[i] = timer_q[i] + 10'd1;
                        end
                    end
                    default: state_n[i] = EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge FrameClk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (Reset) begin
                state_q[i] <= EMPTY;
                value_q[i] <= 2'd0;
                delay_q[i] <= 3'd0;
                timer_q[i] <= 10'd0;
            end else begin
                state_q[i] <= state_n[i];
                value_q[i] <= value_n[i];
                delay_q[i] <= delay_n[i];
                timer_q[i] <= timer_n[i];
            end
        end
    end
endmodule
